gvp_vector_engine: RTL and testbench

//  General Vector Program (GVP) sequencer: holds a small program of vector sections, steps X/Y/Z/U
//  set-points by per-section increments and emits timing, point index, section options and store

---
 rtl/gvp_pkg.sv | 46 ++++
 rtl/gvp_vector_ram.sv | 37 +++
 rtl/gvp_vector_engine.sv | 211 +++++++++++++++++++++
 tb/tb_gvp_vector_engine.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gvp_pkg.sv
// Shared definitions for the GVP vector engine.
// Holds the program-slot word map, the store_data codes, the sequencer state
// encoding and a helper that extracts one 32-bit word from a stored slot.
package gvp_pkg;

  localparam int NVEC       = 16;   // program slots
  localparam int TW         = 48;   // gvp time counter width
  localparam int WORD_W     = 32;
  localparam int SLOT_WORDS = 15;   // w1..w15 are stored, w0 is only the write address
  localparam int SLOT_W     = SLOT_WORDS * WORD_W;

  // Word indices inside a vp_set vector
  localparam int W_VADR  = 0;
  localparam int W_N     = 1;
  localparam int W_NII   = 2;
  localparam int W_OPT   = 3;
  localparam int W_NREP  = 4;
  localparam int W_NEXT  = 5;
  localparam int W_DX    = 6;
  localparam int W_DY    = 7;
  localparam int W_DZ    = 8;
  localparam int W_DU    = 9;
  localparam int W_AA    = 10;
  localparam int W_BB    = 11;
  localparam int W_DECII = 15;

  localparam logic [1:0] STORE_NONE = 2'd0;
  localparam logic [1:0] STORE_DATA = 2'd1;
  localparam logic [1:0] STORE_HDR  = 2'd2;

  localparam logic [TW-1:0] TIME_INC = 48'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } gvp_state_e;

  // Stored slots start at w1, so word k sits at (k-1)*32 in the slot image.
  function automatic logic [WORD_W-1:0] slot_word(input logic [SLOT_W-1:0] slot,
                                                  input int unsigned k);
    return slot[(k-1)*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/gvp_vector_ram.sv
// Program store of the GVP engine: NVEC slots of 480 bits (words w1..w15).
// Ports:
//   i_clk    clock
//   i_we     write enable (level, writes every clock while high)
//   i_waddr  slot to write
//   i_wdata  slot image w1..w15 (w1 in the LSBs)
//   i_raddr  slot read asynchronously (program counter)
//   o_rdata  slot image at i_raddr
//   o_nrep   Nrep word of every slot, used to reload all repeat counters at once
module gvp_vector_ram
  import gvp_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_we,
  input  logic [3:0]              i_waddr,
  input  logic [SLOT_W-1:0]       i_wdata,
  input  logic [3:0]              i_raddr,
  output logic [SLOT_W-1:0]       o_rdata,
  output logic [NVEC-1:0][31:0]   o_nrep
);

  logic [SLOT_W-1:0] r_mem [NVEC];

  // Slot write port; contents survive the sequencer reset on purpose
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

  for (genvar g = 0; g < NVEC; g++) begin : g_nrep
    assign o_nrep[g] = slot_word(r_mem[g], W_NREP);
  end

endmodule

// File: rtl/gvp_vector_engine.sv
// GVP sequencer: walks the vector program, steps the X/Y/Z/U set-points by
// per-section increments and emits point index, time, options and store pulses.
// Ports:
//   a_clk, reset             clock, synchronous active-high hold/rewind
//   setvec, vp_set           program write (slot = vp_set[3:0])
//   reset_options            options driven while idle, in reset or finished
//   pause, stall             freeze sequencing
//   M_AXIS_{X,Y,Z,U}_tdata   set-point accumulators
//   M_AXIS_index_tdata       points remaining in section (N-1 .. 0)
//   M_AXIS_gvp_time_tdata    running clocks since run start
//   options                  current section options
//   store_data               2 header, 1 data point, 0 none
//   gvp_finished             sticky end-of-program flag
module gvp_vector_engine
  import gvp_pkg::*;
(
  input  logic          a_clk,
  input  logic          reset,
  input  logic          setvec,
  input  logic [511:0]  vp_set,
  input  logic [31:0]   reset_options,
  input  logic          pause,
  input  logic          stall,
  output logic [31:0]   M_AXIS_X_tdata,
  output logic [31:0]   M_AXIS_Y_tdata,
  output logic [31:0]   M_AXIS_Z_tdata,
  output logic [31:0]   M_AXIS_U_tdata,
  output logic [31:0]   M_AXIS_index_tdata,
  output logic [TW-1:0] M_AXIS_gvp_time_tdata,
  output logic [31:0]   options,
  output logic [1:0]    store_data,
  output logic          gvp_finished
);

  gvp_state_e r_state, w_state_nxt;

  logic [3:0]            r_pc;
  logic [31:0]           r_dec, r_nii, r_idx;
  logic [31:0]           r_rep_cnt [NVEC];
  logic [31:0]           r_x, r_y, r_z, r_u;
  logic [31:0]           r_index, r_options;
  logic [TW-1:0]         r_time, r_time_out;
  logic [1:0]            r_store;
  logic                  r_finished;

  logic [SLOT_W-1:0]     w_slot;
  logic [NVEC-1:0][31:0] w_nrep_all;
  logic [31:0]           w_n, w_nii, w_opt, w_nrep, w_next, w_decii;
  logic [31:0]           w_dx, w_dy, w_dz, w_du;
  logic                  w_freeze, w_step_end, w_point_end, w_sect_end, w_acc_en;
  logic                  w_unused_bits;

  gvp_vector_ram u_ram (
    .i_clk   (a_clk),
    .i_we    (setvec),
    .i_waddr (vp_set[3:0]),
    .i_wdata (vp_set[511:32]),
    .i_raddr (r_pc),
    .o_rdata (w_slot),
    .o_nrep  (w_nrep_all)
  );

  assign w_n     = slot_word(w_slot, W_N);
  assign w_nii   = slot_word(w_slot, W_NII);
  assign w_opt   = slot_word(w_slot, W_OPT);
  assign w_nrep  = slot_word(w_slot, W_NREP);
  assign w_next  = slot_word(w_slot, W_NEXT);
  assign w_dx    = slot_word(w_slot, W_DX);
  assign w_dy    = slot_word(w_slot, W_DY);
  assign w_dz    = slot_word(w_slot, W_DZ);
  assign w_du    = slot_word(w_slot, W_DU);
  assign w_decii = slot_word(w_slot, W_DECII);

  // AA/BB and reserved words are stored for the host but not used here
  assign w_unused_bits = ^{vp_set[31:4], w_slot[(W_AA-1)*WORD_W +: 5*WORD_W], w_next[31:4]};

  assign w_freeze    = pause | stall;
  assign w_step_end  = (r_dec == w_decii);
  assign w_point_end = w_step_end && (r_nii == w_nii);
  assign w_sect_end  = w_point_end && (r_idx == 32'd0);
  assign w_acc_en    = !reset && (r_state == S_STEP) && !w_freeze && w_step_end;

  // State register
  always_ff @(posedge a_clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; a frozen clock keeps the current state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (w_freeze) begin
          w_state_nxt = S_LOAD;
        end else if (w_n == 32'd0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_STEP;
        end
      end
      S_STEP: begin
        if (!w_freeze && w_sect_end) begin
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_STEP;
        end
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sequencer counters, program counter, repeat counters and stream outputs
  always_ff @(posedge a_clk) begin
    if (reset) begin
      r_pc       <= 4'd0;
      r_dec      <= 32'd0;
      r_nii      <= 32'd0;
      r_idx      <= 32'd0;
      r_index    <= 32'd0;
      r_time     <= 48'd0;
      r_time_out <= 48'd0;
      r_store    <= STORE_NONE;
      r_finished <= 1'b0;
      r_options  <= reset_options;
      for (int i = 0; i < NVEC; i++) begin
        r_rep_cnt[i] <= w_nrep_all[i];
      end
    end else begin
      r_store <= STORE_NONE;
      case (r_state)
        S_IDLE: r_options <= reset_options;
        S_LOAD: begin
          if (!w_freeze) begin
            // Time output carries the stamp of the clock the event belongs to
            r_time     <= r_time + TIME_INC;
            r_time_out <= r_time;
            if (w_n == 32'd0) begin
              r_finished <= 1'b1;
              r_options  <= reset_options;
            end else begin
              r_idx     <= w_n - 32'd1;
              r_index   <= w_n - 32'd1;
              r_options <= w_opt;
              r_store   <= STORE_HDR;
              r_dec     <= 32'd0;
              r_nii     <= 32'd0;
            end
          end
        end
        S_STEP: begin
          if (!w_freeze) begin
            r_time     <= r_time + TIME_INC;
            r_time_out <= r_time;
            r_index    <= r_idx;
            if (w_step_end) begin
              r_dec <= 32'd0;
              if (w_point_end) begin
                r_nii   <= 32'd0;
                r_store <= STORE_DATA;
                r_idx   <= r_idx - 32'd1;
                if (w_sect_end) begin
                  // Repeat via relative jump until the slot's counter is spent
                  if (r_rep_cnt[r_pc] != 32'd0) begin
                    r_rep_cnt[r_pc] <= r_rep_cnt[r_pc] - 32'd1;
                    r_pc            <= r_pc + w_next[3:0];
                  end else begin
                    r_rep_cnt[r_pc] <= w_nrep;
                    r_pc            <= r_pc + 4'd1;
                  end
                end
              end else begin
                r_nii <= r_nii + 32'd1;
              end
            end else begin
              r_dec <= r_dec + 32'd1;
            end
          end
        end
        S_DONE:  r_options <= reset_options;
        default: r_options <= reset_options;
      endcase
    end
  end

  // Set-point accumulators; deliberately not cleared so a rerun starts from the held position
  always_ff @(posedge a_clk) begin
    if (w_acc_en) begin
      r_x <= r_x + w_dx;
      r_y <= r_y + w_dy;
      r_z <= r_z + w_dz;
      r_u <= r_u + w_du;
    end
  end

  assign M_AXIS_X_tdata        = r_x;
  assign M_AXIS_Y_tdata        = r_y;
  assign M_AXIS_Z_tdata        = r_z;
  assign M_AXIS_U_tdata        = r_u;
  assign M_AXIS_index_tdata    = r_index;
  assign M_AXIS_gvp_time_tdata = r_time_out;
  assign options               = r_options;
  assign store_data            = r_store;
  assign gvp_finished          = r_finished;

endmodule

// File: tb/tb_gvp_vector_engine.sv
module tb_gvp_vector_engine;

  logic         a_clk = 1'b0;
  logic         reset = 1'b1;
  logic         setvec = 1'b0;
  logic [511:0] vp_set = '0;
  logic [31:0]  reset_options = 32'h0000_00A5;
  logic         pause = 1'b0;
  logic         stall = 1'b0;
  logic [31:0]  M_AXIS_X_tdata, M_AXIS_Y_tdata, M_AXIS_Z_tdata, M_AXIS_U_tdata;
  logic [31:0]  M_AXIS_index_tdata;
  logic [47:0]  M_AXIS_gvp_time_tdata;
  logic [31:0]  options;
  logic [1:0]   store_data;
  logic         gvp_finished;

  gvp_vector_engine dut (
    .a_clk                 (a_clk),
    .reset                 (reset),
    .setvec                (setvec),
    .vp_set                (vp_set),
    .reset_options         (reset_options),
    .pause                 (pause),
    .stall                 (stall),
    .M_AXIS_X_tdata        (M_AXIS_X_tdata),
    .M_AXIS_Y_tdata        (M_AXIS_Y_tdata),
    .M_AXIS_Z_tdata        (M_AXIS_Z_tdata),
    .M_AXIS_U_tdata        (M_AXIS_U_tdata),
    .M_AXIS_index_tdata    (M_AXIS_index_tdata),
    .M_AXIS_gvp_time_tdata (M_AXIS_gvp_time_tdata),
    .options               (options),
    .store_data            (store_data),
    .gvp_finished          (gvp_finished)
  );

  always #5 a_clk = ~a_clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_data, n_hdr, peak_rel;
  logic [31:0] base_x, base_y, base_z, base_u;
  logic [31:0] hdr_opt, hx, hy, hz, hu;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock, then sample and tally the stream
  task automatic tick();
    int rel;
    @(posedge a_clk);
    #1;
    if (store_data == 2'd1) n_data++;
    if (store_data == 2'd2) begin
      n_hdr++;
      if (n_hdr == 1) hdr_opt = options;
      if (n_hdr == 2) begin
        hx = M_AXIS_X_tdata; hy = M_AXIS_Y_tdata; hz = M_AXIS_Z_tdata; hu = M_AXIS_U_tdata;
      end
    end
    rel = $signed(M_AXIS_U_tdata - base_u);
    if (rel > peak_rel) peak_rel = rel;
  endtask

  task automatic clear_tally();
    n_data = 0; n_hdr = 0; peak_rel = 0; hdr_opt = '0;
    base_x = M_AXIS_X_tdata; base_y = M_AXIS_Y_tdata;
    base_z = M_AXIS_Z_tdata; base_u = M_AXIS_U_tdata;
  endtask

  task automatic prog(input logic [3:0] slot, input logic [31:0] n, input logic [31:0] nii,
                      input logic [31:0] decii, input logic [31:0] opt, input logic [31:0] nrep,
                      input logic [31:0] nxt, input logic [31:0] dx, input logic [31:0] dy,
                      input logic [31:0] dz, input logic [31:0] du);
    vp_set = '0;
    vp_set[3:0]        = slot;
    vp_set[32*1  +: 32] = n;
    vp_set[32*2  +: 32] = nii;
    vp_set[32*3  +: 32] = opt;
    vp_set[32*4  +: 32] = nrep;
    vp_set[32*5  +: 32] = nxt;
    vp_set[32*6  +: 32] = dx;
    vp_set[32*7  +: 32] = dy;
    vp_set[32*8  +: 32] = dz;
    vp_set[32*9  +: 32] = du;
    vp_set[32*15 +: 32] = decii;
    setvec = 1'b1;
    @(posedge a_clk);
    #1;
    setvec = 1'b0;
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    tick();
    tick();
  endtask

  task automatic run_prog(input string tag, input int budget);
    int cyc;
    clear_tally();
    reset = 1'b0;
    cyc = 0;
    while (!gvp_finished && cyc < budget) begin
      tick();
      cyc++;
    end
    check_val({tag, "_finished"}, {63'd0, gvp_finished}, 64'd1);
  endtask

  task automatic prog_ramp();
    prog(4'd0, 32'd16, 32'd2, 32'd16, 32'h000C0801, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd10);
    prog(4'd1, 32'd16, 32'd2, 32'd16, 32'h000C0801, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, -32'sd10);
    prog(4'd2, 32'd0,  32'd0, 32'd0,  32'd0,        32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] u_hold, t_hold, i_hold;
    int          pulses_before;

    // Reset state
    hold_reset();
    check_val("rst_store",    {62'd0, store_data}, 64'd0);
    check_val("rst_finished", {63'd0, gvp_finished}, 64'd0);
    check_val("rst_options",  {32'd0, options}, 64'hA5);
    check_val("rst_index",    {32'd0, M_AXIS_index_tdata}, 64'd0);
    check_val("rst_time",     {16'd0, M_AXIS_gvp_time_tdata}, 64'd0);

    // Timing: one clock per point
    prog(4'd0, 32'd3, 32'd0, 32'd0, 32'h11, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    prog(4'd1, 32'd0, 32'd0, 32'd0, 32'd0,  32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    hold_reset();
    clear_tally();
    reset = 1'b0;
    tick();
    tick();
    check_val("tim_hdr_store", {62'd0, store_data}, 64'd2);
    check_val("tim_hdr_time",  {16'd0, M_AXIS_gvp_time_tdata}, 64'd0);
    check_val("tim_hdr_index", {32'd0, M_AXIS_index_tdata}, 64'd2);
    check_val("tim_hdr_opt",   {32'd0, options}, 64'h11);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val("tim_pt_store", {62'd0, store_data}, 64'd1);
      check_val("tim_pt_index", {32'd0, M_AXIS_index_tdata}, 64'(2 - k));
      check_val("tim_pt_time",  {16'd0, M_AXIS_gvp_time_tdata}, 64'(1 + k));
    end
    tick();
    check_val("tim_end_store", {62'd0, store_data}, 64'd0);
    check_val("tim_end_fin",   {63'd0, gvp_finished}, 64'd1);

    // Ramp up/down on U
    reset = 1'b1;
    prog_ramp();
    hold_reset();
    run_prog("ramp", 3000);
    check_val("ramp_data",  64'(n_data), 64'd32);
    check_val("ramp_hdr",   64'(n_hdr), 64'd2);
    check_val("ramp_peak",  64'(peak_rel), 64'd480);
    check_val("ramp_u_end", {32'd0, M_AXIS_U_tdata}, {32'd0, base_u});
    check_val("ramp_opt",   {32'd0, hdr_opt}, 64'h000C0801);
    check_val("ramp_time",  {16'd0, M_AXIS_gvp_time_tdata}, 64'd1634);
    check_val("ramp_ropt",  {32'd0, options}, 64'hA5);
    repeat (5) tick();
    check_val("ramp_sticky", {63'd0, gvp_finished}, 64'd1);
    check_val("ramp_t_hold", {16'd0, M_AXIS_gvp_time_tdata}, 64'd1634);

    // Multi-axis, run twice through a reset toggle
    reset = 1'b1;
    prog(4'd0, 32'd5, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4);
    prog(4'd1, 32'd5, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0, -32'sd1, -32'sd2, -32'sd3, -32'sd4);
    prog(4'd2, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    for (int r = 0; r < 2; r++) begin
      hold_reset();
      run_prog("axis", 200);
      check_val("axis_x_mid", {32'd0, hx - base_x}, 64'd15);
      check_val("axis_y_mid", {32'd0, hy - base_y}, 64'd30);
      check_val("axis_z_mid", {32'd0, hz - base_z}, 64'd45);
      check_val("axis_u_mid", {32'd0, hu - base_u}, 64'd60);
      check_val("axis_x_end", {32'd0, M_AXIS_X_tdata}, {32'd0, base_x});
      check_val("axis_u_end", {32'd0, M_AXIS_U_tdata}, {32'd0, base_u});
      check_val("axis_data",  64'(n_data), 64'd10);
      check_val("axis_time",  {16'd0, M_AXIS_gvp_time_tdata}, 64'd32);
    end

    // Nested loop: slots 0/1 repeated through slot 2's backward jump
    reset = 1'b1;
    prog(4'd0, 32'd10, 32'd128, 32'd0, 32'd0, 32'd0,  32'd0,       32'd256,  32'd0, 32'd0, 32'd0);
    prog(4'd1, 32'd10, 32'd128, 32'd0, 32'd0, 32'd0,  32'd0,       -32'sd256, 32'd0, 32'd0, 32'd0);
    prog(4'd2, 32'd1,  32'd128, 32'd0, 32'd0, 32'd10, 32'hFFFFFFFE, 32'd0,   32'd64, 32'd0, 32'd0);
    prog(4'd3, 32'd0,  32'd0,   32'd0, 32'd0, 32'd0,  32'd0,       32'd0,    32'd0,  32'd0, 32'd0);
    hold_reset();
    run_prog("loop", 40000);
    check_val("loop_y",    {32'd0, M_AXIS_Y_tdata - base_y}, 64'd90816);
    check_val("loop_x",    {32'd0, M_AXIS_X_tdata}, {32'd0, base_x});
    check_val("loop_data", 64'(n_data), 64'd231);
    check_val("loop_hdr",  64'(n_hdr), 64'd33);
    check_val("loop_time", {16'd0, M_AXIS_gvp_time_tdata}, 64'd29832);

    // Stall and pause mid-point
    reset = 1'b1;
    prog(4'd0, 32'd4, 32'd1, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd5);
    prog(4'd1, 32'd4, 32'd1, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, -32'sd5);
    prog(4'd2, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    hold_reset();
    clear_tally();
    reset = 1'b0;
    repeat (30) tick();
    u_hold = M_AXIS_U_tdata;
    t_hold = M_AXIS_gvp_time_tdata[31:0];
    i_hold = M_AXIS_index_tdata;
    pulses_before = n_data + n_hdr;
    stall = 1'b1;
    repeat (50) tick();
    check_val("stall_pulses", 64'(n_data + n_hdr), 64'(pulses_before));
    check_val("stall_time",   {32'd0, M_AXIS_gvp_time_tdata[31:0]}, {32'd0, t_hold});
    check_val("stall_u",      {32'd0, M_AXIS_U_tdata}, {32'd0, u_hold});
    check_val("stall_index",  {32'd0, M_AXIS_index_tdata}, {32'd0, i_hold});
    pause = 1'b1;
    repeat (5) tick();
    stall = 1'b0;
    repeat (5) tick();
    check_val("pause_pulses", 64'(n_data + n_hdr), 64'(pulses_before));
    check_val("pause_time",   {32'd0, M_AXIS_gvp_time_tdata[31:0]}, {32'd0, t_hold});
    pause = 1'b0;
    begin
      int cyc = 0;
      while (!gvp_finished && cyc < 400) begin
        tick();
        cyc++;
      end
    end
    check_val("stall_finished", {63'd0, gvp_finished}, 64'd1);
    check_val("stall_data",     64'(n_data), 64'd8);
    check_val("stall_peak",     64'(peak_rel), 64'd40);
    check_val("stall_u_end",    {32'd0, M_AXIS_U_tdata}, {32'd0, base_u});
    check_val("stall_t_end",    {16'd0, M_AXIS_gvp_time_tdata}, 64'd162);

    // Reset mid-section, then rerun from the held position
    reset = 1'b1;
    prog_ramp();
    hold_reset();
    clear_tally();
    reset = 1'b0;
    repeat (100) tick();
    u_hold = M_AXIS_U_tdata;
    reset = 1'b1;
    tick();
    check_val("mid_store",    {62'd0, store_data}, 64'd0);
    check_val("mid_time",     {16'd0, M_AXIS_gvp_time_tdata}, 64'd0);
    check_val("mid_index",    {32'd0, M_AXIS_index_tdata}, 64'd0);
    check_val("mid_options",  {32'd0, options}, 64'hA5);
    check_val("mid_finished", {63'd0, gvp_finished}, 64'd0);
    check_val("mid_u_hold",   {32'd0, M_AXIS_U_tdata}, {32'd0, u_hold});
    tick();
    run_prog("rerun", 3000);
    check_val("rerun_data", 64'(n_data), 64'd32);
    check_val("rerun_hdr",  64'(n_hdr), 64'd2);
    check_val("rerun_peak", 64'(peak_rel), 64'd480);
    check_val("rerun_u",    {32'd0, M_AXIS_U_tdata}, {32'd0, u_hold});
    check_val("rerun_time", {16'd0, M_AXIS_gvp_time_tdata}, 64'd1634);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
